// File: rtl/nes_controller_responder.sv
// nes_controller_responder: device-side NES controller (4021-style PISO) with debounced buttons
module nes_controller_responder #(
  parameter int DEBOUNCE_CYCLES = 2048
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       nes_latch,
  input  logic       nes_pulse,
  input  logic [7:0] buttons,
  output logic       nes_data,
  output logic       frame_done,
  output logic       pulse_overrun,
  output logic [7:0] btn_stable
);
  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;
  localparam logic [15:0] CNT_MAX = 16'(DEBOUNCE_CYCLES - 1);
  // [0] first sync stage, [1] synchronized level, [2] previous level for edges
  logic [2:0] latch_q, pulse_q;
  logic [7:0] btn_s1_q, btn_s2_q;
  logic [7:0][15:0] cnt_q, cnt_d;
  logic [7:0] stable_q, stable_d;
  state_t state_q;
  logic [7:0] sr_q;
  logic [2:0] shift_cnt_q;
  logic frame_done_q, overrun_q;
  logic latch_fall, pulse_rise;
  assign latch_fall = ~latch_q[1] & latch_q[2];
  assign pulse_rise = pulse_q[1] & ~pulse_q[2];
  assign nes_data = sr_q[7];
  assign frame_done = frame_done_q;
  assign pulse_overrun = overrun_q;
  assign btn_stable = stable_q;
  // bring host lines and raw buttons into the clk domain
  always_ff @(posedge clk) begin
    if (reset) begin
      latch_q <= '0;
      pulse_q <= '0;
      btn_s1_q <= '0;
      btn_s2_q <= '0;
    end else begin
      latch_q <= {latch_q[1:0], nes_latch};
      pulse_q <= {pulse_q[1:0], nes_pulse};
      btn_s1_q <= buttons;
      btn_s2_q <= btn_s1_q;
    end
  end
  // per-bit debounce: a differing level must persist DEBOUNCE_CYCLES cycles to be accepted
  always_comb begin
    cnt_d = cnt_q;
    stable_d = stable_q;
    for (int i = 0; i < 8; i++) begin
      cnt_d[i] = (btn_s2_q[i] == stable_q[i] || cnt_q[i] == CNT_MAX) ? 16'd0 : cnt_q[i] + 16'd1;
      stable_d[i] = (btn_s2_q[i] != stable_q[i] && cnt_q[i] == CNT_MAX) ? btn_s2_q[i] : stable_q[i];
    end
  end
  // debounce state registers
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      stable_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      stable_q <= stable_d;
    end
  end
  // frame sequencer; a high latch overrides everything, including a coincident pulse rise
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      sr_q <= 8'hFF;
      shift_cnt_q <= '0;
      frame_done_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      overrun_q <= 1'b0;
      if (latch_q[1]) begin
        state_q <= LOAD;
        sr_q <= ~stable_q;
      end else begin
        case (state_q)
          LOAD: if (latch_fall) begin
            state_q <= SHIFT;
            shift_cnt_q <= '0;
          end
          SHIFT: if (pulse_rise) begin
            sr_q <= {sr_q[6:0], 1'b1};
            shift_cnt_q <= shift_cnt_q + 3'd1;
            if (shift_cnt_q == 3'd7) begin
              frame_done_q <= 1'b1;
              state_q <= DONE;
            end
          end
          DONE: overrun_q <= pulse_rise;
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_nes_controller_responder.sv
// tb_nes_controller_responder: vector table, random frames/bounces and corner sequences against a behavioural model
module tb_nes_controller_responder;
  localparam int D = 16;
  typedef struct {
    logic [7:0] btn;
    int hi;
    int lo;
    int extra;
    logic [7:0] seq;
    int ovr;
  } vec_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic nes_latch = 1'b0;
  logic nes_pulse = 1'b0;
  logic [7:0] buttons = 8'h00;
  logic nes_data, frame_done, pulse_overrun;
  logic [7:0] btn_stable;
  int n_cmp = 0;
  int n_err = 0;
  int fd_cnt = 0;
  int ov_cnt = 0;
  bit mon_on = 1'b0;
  logic [7:0] m_stable = 8'h00;
  logic [7:0] pipe1 = 8'h00;
  logic [7:0] pipe2 = 8'h00;
  logic [7:0] win[$];

  nes_controller_responder #(.DEBOUNCE_CYCLES(D)) dut (
    .clk(clk),
    .reset(reset),
    .nes_latch(nes_latch),
    .nes_pulse(nes_pulse),
    .buttons(buttons),
    .nes_data(nes_data),
    .frame_done(frame_done),
    .pulse_overrun(pulse_overrun),
    .btn_stable(btn_stable)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Reference debounce: the pin reaches the filter two cycles late; a bit flips once the
  // last D filter samples all disagree with the accepted level.
  always @(posedge clk) begin
    logic [7:0] all_diff;
    if (reset) begin
      pipe1 = 8'h00;
      pipe2 = 8'h00;
      win.delete();
      m_stable = 8'h00;
    end else begin
      win.push_back(pipe2);
      if (win.size() > D) void'(win.pop_front());
      all_diff = (win.size() == D) ? 8'hFF : 8'h00;
      foreach (win[j]) all_diff &= win[j] ^ m_stable;
      m_stable ^= all_diff;
      pipe2 = pipe1;
      pipe1 = buttons;
    end
  end

  always @(negedge clk) begin
    if (frame_done) fd_cnt++;
    if (pulse_overrun) ov_cnt++;
    if (mon_on) chk("btn_stable", 32'(btn_stable), 32'(m_stable));
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse(input int hi, input int lo);
    nes_pulse = 1'b1;
    cyc(hi);
    nes_pulse = 1'b0;
    cyc(lo);
  endtask

  task automatic latch(input int n);
    nes_latch = 1'b1;
    cyc(n);
    nes_latch = 1'b0;
    cyc(3);
  endtask

  task automatic settle(input logic [7:0] b);
    buttons = b;
    cyc(D + 6);
  endtask

  task automatic frame(input logic [7:0] seq, input int hi, input int lo, input string tag);
    int f0, o0;
    f0 = fd_cnt;
    o0 = ov_cnt;
    for (int i = 7; i >= 0; i--) begin
      chk({tag, "_bit"}, 32'(nes_data), 32'(seq[i]));
      pulse(hi, lo);
    end
    chk({tag, "_frame_done"}, 32'(fd_cnt - f0), 32'd1);
    chk({tag, "_no_overrun"}, 32'(ov_cnt - o0), 32'd0);
    chk({tag, "_tail"}, 32'(nes_data), 32'd1);
  endtask

  initial begin
    vec_t vecs[5];
    logic [7:0] b;
    int hi, lo, ex, o0, f0;
    vecs[0] = '{8'b1001_0100, 150, 150, 2, 8'b0110_1011, 2};
    vecs[1] = '{8'hFF, 3, 3, 0, 8'h00, 0};
    vecs[2] = '{8'h00, 2, 3, 1, 8'hFF, 1};
    vecs[3] = '{8'hA5, 5, 4, 3, 8'h5A, 3};
    vecs[4] = '{8'h3C, 2, 2, 1, 8'hC3, 1};
    reset = 1'b1;
    cyc(3);
    chk("rst_data", 32'(nes_data), 32'd1);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    chk("rst_overrun", 32'(pulse_overrun), 32'd0);
    chk("rst_btn", 32'(btn_stable), 32'd0);
    reset = 1'b0;
    mon_on = 1'b1;
    cyc(2);
    chk("idle_data", 32'(nes_data), 32'd1);
    foreach (vecs[v]) begin
      settle(vecs[v].btn);
      latch(10);
      frame(vecs[v].seq, vecs[v].hi, vecs[v].lo, "vec");
      o0 = ov_cnt;
      repeat (vecs[v].extra) pulse(vecs[v].hi, vecs[v].lo);
      chk("vec_overrun", 32'(ov_cnt - o0), 32'(vecs[v].ovr));
      chk("vec_after_data", 32'(nes_data), 32'd1);
    end
    for (int r = 0; r < 8; r++) begin
      b = 8'($urandom);
      hi = $urandom_range(2, 8);
      lo = $urandom_range(2, 8);
      ex = $urandom_range(0, 3);
      settle(b);
      latch($urandom_range(2, 12));
      frame(~b, hi, lo, "rnd");
      o0 = ov_cnt;
      repeat (ex) pulse(hi, lo);
      chk("rnd_overrun", 32'(ov_cnt - o0), 32'(ex));
    end
    for (int r = 0; r < 40; r++) begin
      buttons = 8'($urandom);
      cyc($urandom_range(1, 2 * D));
    end
    settle(8'h00);
    for (int i = 0; i < 10; i++) begin
      buttons[7] = ~buttons[7];
      cyc(5);
    end
    buttons[7] = 1'b1;
    cyc(17);
    chk("bounce_settle_17", 32'(btn_stable[7]), 32'd0);
    cyc(1);
    chk("bounce_settle_18", 32'(btn_stable[7]), 32'd1);
    buttons[7] = 1'b0;
    cyc(10);
    buttons[7] = 1'b1;
    cyc(D + 6);
    chk("glitch_hold_a", 32'(btn_stable[7]), 32'd1);
    buttons[0] = 1'b1;
    cyc(10);
    buttons[0] = 1'b0;
    cyc(D + 6);
    chk("glitch_hold_right", 32'(btn_stable[0]), 32'd0);
    settle(8'b1001_0100);
    latch(10);
    repeat (3) pulse(3, 3);
    chk("abort_pre_data", 32'(nes_data), 32'd0);
    f0 = fd_cnt;
    latch(5);
    chk("abort_reload", 32'(nes_data), 32'd0);
    chk("abort_no_fd", 32'(fd_cnt - f0), 32'd0);
    frame(8'b0110_1011, 3, 3, "abort");
    latch(10);
    nes_latch = 1'b1;
    nes_pulse = 1'b1;
    cyc(3);
    chk("collide_edge", 32'(nes_data), 32'd0);
    cyc(1);
    chk("collide_hold", 32'(nes_data), 32'd0);
    nes_pulse = 1'b0;
    cyc(2);
    nes_latch = 1'b0;
    cyc(3);
    frame(8'b0110_1011, 4, 4, "collide");
    latch(10);
    repeat (3) pulse(3, 3);
    reset = 1'b1;
    cyc(3);
    reset = 1'b0;
    chk("midrst_data", 32'(nes_data), 32'd1);
    chk("midrst_frame_done", 32'(frame_done), 32'd0);
    chk("midrst_btn", 32'(btn_stable), 32'd0);
    nes_latch = 1'b1;
    cyc(4);
    chk("midrst_first_load", 32'(nes_data), 32'd1);
    nes_latch = 1'b0;
    cyc(D + 6);
    latch(10);
    frame(8'b0110_1011, 3, 3, "postrst");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
